// File: rtl/pkt_addr_counter.sv
// Address generator for a circular packet buffer.
// The write side opens a packet, advances per written entry and then either
// commits the packet (entries become readable) or rolls back to the address
// where the packet started. The read side consumes committed entries only.
// Occupancy is tracked as committed count plus pending (uncommitted) entries.
module pkt_addr_counter #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_start,
    input  logic              wr_en,
    input  logic              wr_commit,
    input  logic              wr_error,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   pending,
    output logic              full,
    output logic              empty,
    output logic              in_pkt,
    output logic              wrap_flag,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);

    // Circular successor: DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == LAST_ADDR) begin
            r = ADDR_ZERO;
        end else begin
            r = a + ADDR_ONE;
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
    logic [ADDR_W-1:0] mark_r, mark_s;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic [ADDR_W:0]   pending_r, pending_s;
    logic [ADDR_W:0]   commit_amt_s;
    logic [ADDR_W:0]   rd_take_s;
    logic              full_r, full_s;
    logic              empty_r, empty_s;
    logic              wrap_r, wrap_s;
    logic              ovf_r, ovf_s;
    logic              udf_r, udf_s;

    // Next-state, address and occupancy decode for write and read sides.
    always_comb begin
        state_s      = state_r;
        wr_addr_s    = wr_addr_r;
        rd_addr_s    = rd_addr_r;
        mark_s       = mark_r;
        pending_s    = pending_r;
        base_s       = wr_addr_r;
        commit_amt_s = CNT_ZERO;
        rd_take_s    = CNT_ZERO;
        wrap_s       = 1'b0;
        ovf_s        = 1'b0;
        udf_s        = 1'b0;

        if (wr_error && (state_r == ST_PKT)) begin
            // Abort: drop the open packet; error overrides write and commit.
            wr_addr_s = mark_r;
            pending_s = CNT_ZERO;
            state_s   = ST_IDLE;
        end else if (wr_start && !wr_error) begin
            // (Re)start: a restart inside a packet first rolls back to the mark.
            if (state_r == ST_PKT) begin
                base_s = mark_r;
            end else begin
                base_s = wr_addr_r;
            end
            mark_s    = base_s;
            wr_addr_s = base_s;
            pending_s = CNT_ZERO;
            state_s   = ST_PKT;
            if (wr_en) begin
                if (count_r < DEPTH_C) begin
                    wr_addr_s = addr_inc(base_s);
                    pending_s = CNT_ONE;
                    wrap_s    = (base_s == LAST_ADDR);
                end else begin
                    ovf_s = 1'b1;
                end
            end else begin
                ovf_s = 1'b0;
            end
        end else if (state_r == ST_PKT) begin
            if (wr_en) begin
                if ((count_r + pending_r) < DEPTH_C) begin
                    wr_addr_s = addr_inc(wr_addr_r);
                    pending_s = pending_r + CNT_ONE;
                    wrap_s    = (wr_addr_r == LAST_ADDR);
                end else begin
                    ovf_s = 1'b1;
                end
            end else begin
                ovf_s = 1'b0;
            end
            if (wr_commit) begin
                // Commit includes a write made in this same cycle.
                commit_amt_s = pending_s;
                pending_s    = CNT_ZERO;
                state_s      = ST_IDLE;
            end else begin
                commit_amt_s = CNT_ZERO;
            end
        end else begin
            // No packet open: any write request is dropped.
            ovf_s = wr_en;
        end

        if (rd_en) begin
            if (count_r != CNT_ZERO) begin
                rd_addr_s = addr_inc(rd_addr_r);
                rd_take_s = CNT_ONE;
            end else begin
                udf_s = 1'b1;
            end
        end else begin
            rd_take_s = CNT_ZERO;
        end

        count_s = count_r + commit_amt_s - rd_take_s;
        full_s  = ((count_s + pending_s) == DEPTH_C);
        empty_s = (count_s == CNT_ZERO);
    end

    // State and output registers; rst and clear both return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r   <= ST_IDLE;
            wr_addr_r <= ADDR_ZERO;
            rd_addr_r <= ADDR_ZERO;
            mark_r    <= ADDR_ZERO;
            count_r   <= CNT_ZERO;
            pending_r <= CNT_ZERO;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            wrap_r    <= 1'b0;
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_addr_r <= wr_addr_s;
            rd_addr_r <= rd_addr_s;
            mark_r    <= mark_s;
            count_r   <= count_s;
            pending_r <= pending_s;
            full_r    <= full_s;
            empty_r   <= empty_s;
            wrap_r    <= wrap_s;
            ovf_r     <= ovf_s;
            udf_r     <= udf_s;
        end
    end

    assign wr_addr   = wr_addr_r;
    assign rd_addr   = rd_addr_r;
    assign count     = count_r;
    assign pending   = pending_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign in_pkt    = (state_r == ST_PKT);
    assign wrap_flag = wrap_r;
    assign overflow  = ovf_r;
    assign underflow = udf_r;

endmodule

// File: tb/tb_pkt_addr_counter.sv
// Scoreboard bench for pkt_addr_counter: one DEPTH=16 and one DEPTH=12 instance
// share the same stimulus; a queue-based reference model per instance predicts
// every cycle's outputs, and a monitor compares them after each clock edge.
module tb_pkt_addr_counter;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic rst = 1'b0, clear = 1'b0, wr_start = 1'b0, wr_en = 1'b0;
    logic wr_commit = 1'b0, wr_error = 1'b0, rd_en = 1'b0;

    logic [3:0] a_wa, a_ra, b_wa, b_ra;
    logic [4:0] a_cnt, a_pend, b_cnt, b_pend;
    logic a_full, a_empty, a_inpkt, a_wrap, a_ovf, a_udf;
    logic b_full, b_empty, b_inpkt, b_wrap, b_ovf, b_udf;

    pkt_addr_counter #(.ADDR_W(4), .DEPTH(16)) dut16 (
        .clk(tb_clk), .rst(rst), .clear(clear), .wr_start(wr_start), .wr_en(wr_en),
        .wr_commit(wr_commit), .wr_error(wr_error), .rd_en(rd_en),
        .wr_addr(a_wa), .rd_addr(a_ra), .count(a_cnt), .pending(a_pend),
        .full(a_full), .empty(a_empty), .in_pkt(a_inpkt), .wrap_flag(a_wrap),
        .overflow(a_ovf), .underflow(a_udf));

    pkt_addr_counter #(.ADDR_W(4), .DEPTH(12)) dut12 (
        .clk(tb_clk), .rst(rst), .clear(clear), .wr_start(wr_start), .wr_en(wr_en),
        .wr_commit(wr_commit), .wr_error(wr_error), .rd_en(rd_en),
        .wr_addr(b_wa), .rd_addr(b_ra), .count(b_cnt), .pending(b_pend),
        .full(b_full), .empty(b_empty), .in_pkt(b_inpkt), .wrap_flag(b_wrap),
        .overflow(b_ovf), .underflow(b_udf));

    typedef struct {
        int wa; int ra; int mark; int cnt; int pend;
        bit inpkt; bit wrap; bit ovf; bit udf;
    } mstate_t;

    mstate_t m16, m12;
    mstate_t q16[$];
    mstate_t q12[$];
    int total = 0;
    int bad = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one clock of buffer behaviour in plain integer terms.
    function automatic mstate_t mstep(input mstate_t s, input int d,
                                      input bit r, input bit c, input bit st, input bit we,
                                      input bit cm, input bit er, input bit re);
        mstate_t n;
        int base;
        int amt;
        int taken;
        n = s;
        n.wrap = 0; n.ovf = 0; n.udf = 0;
        amt = 0; taken = 0;
        if (r || c) begin
            n.wa = 0; n.ra = 0; n.mark = 0; n.cnt = 0; n.pend = 0; n.inpkt = 0;
            return n;
        end
        if (s.inpkt && er) begin
            n.wa = s.mark; n.pend = 0; n.inpkt = 0;
        end else if (st && !er) begin
            base = s.inpkt ? s.mark : s.wa;
            n.mark = base; n.wa = base; n.pend = 0; n.inpkt = 1;
            if (we) begin
                if (s.cnt < d) begin
                    n.wa = (base + 1) % d; n.pend = 1; n.wrap = (base == d - 1);
                end else n.ovf = 1;
            end
        end else if (s.inpkt) begin
            if (we) begin
                if (s.cnt + s.pend < d) begin
                    n.wa = (s.wa + 1) % d; n.pend = s.pend + 1; n.wrap = (s.wa == d - 1);
                end else n.ovf = 1;
            end
            if (cm) begin
                amt = n.pend; n.pend = 0; n.inpkt = 0;
            end
        end else begin
            n.ovf = we;
        end
        if (re) begin
            if (s.cnt > 0) begin
                n.ra = (s.ra + 1) % d; taken = 1;
            end else n.udf = 1;
        end
        n.cnt = s.cnt + amt - taken;
        return n;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the predictions.
    task automatic step(input bit r, input bit c, input bit st, input bit we,
                        input bit cm, input bit er, input bit re);
        @(negedge tb_clk);
        rst = r; clear = c; wr_start = st; wr_en = we;
        wr_commit = cm; wr_error = er; rd_en = re;
        m16 = mstep(m16, 16, r, c, st, we, cm, er, re);
        m12 = mstep(m12, 12, r, c, st, we, cm, er, re);
        q16.push_back(m16);
        q12.push_back(m12);
    endtask

    // Wait until the just-driven cycle has been clocked in.
    task automatic settle();
        @(posedge tb_clk);
        #2;
    endtask

    // Monitor: after every edge, pop each instance's prediction and compare.
    initial begin
        mstate_t e;
        forever begin
            @(posedge tb_clk);
            #1;
            if (q16.size() > 0) begin
                e = q16.pop_front();
                cmp("d16_wr_addr", int'(a_wa), e.wa);
                cmp("d16_rd_addr", int'(a_ra), e.ra);
                cmp("d16_count", int'(a_cnt), e.cnt);
                cmp("d16_pending", int'(a_pend), e.pend);
                cmp("d16_full", int'(a_full), int'(e.cnt + e.pend == 16));
                cmp("d16_empty", int'(a_empty), int'(e.cnt == 0));
                cmp("d16_in_pkt", int'(a_inpkt), int'(e.inpkt));
                cmp("d16_wrap", int'(a_wrap), int'(e.wrap));
                cmp("d16_overflow", int'(a_ovf), int'(e.ovf));
                cmp("d16_underflow", int'(a_udf), int'(e.udf));
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                cmp("d12_wr_addr", int'(b_wa), e.wa);
                cmp("d12_rd_addr", int'(b_ra), e.ra);
                cmp("d12_count", int'(b_cnt), e.cnt);
                cmp("d12_pending", int'(b_pend), e.pend);
                cmp("d12_full", int'(b_full), int'(e.cnt + e.pend == 12));
                cmp("d12_empty", int'(b_empty), int'(e.cnt == 0));
                cmp("d12_in_pkt", int'(b_inpkt), int'(e.inpkt));
                cmp("d12_wrap", int'(b_wrap), int'(e.wrap));
                cmp("d12_overflow", int'(b_ovf), int'(e.ovf));
                cmp("d12_underflow", int'(b_udf), int'(e.udf));
            end
        end
    end

    // Stimulus: directed scenarios with fixed-value spot checks, then random traffic.
    initial begin
        m16 = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        m12 = m16;

        // Reset held two cycles with write and read requested.
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        settle();
        cmp("rst_wr_addr", int'(a_wa), 0);
        cmp("rst_count", int'(a_cnt), 0);
        cmp("rst_empty", int'(a_empty), 1);
        cmp("rst_pulses", int'({a_ovf, a_udf, a_wrap}), 0);

        // Commit a 4-entry packet then drain it.
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        settle();
        cmp("commit_wr_addr", int'(a_wa), 4);
        cmp("commit_count", int'(a_cnt), 4);
        cmp("commit_in_pkt", int'(a_inpkt), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
        settle();
        cmp("drain_rd_addr", int'(a_ra), 4);
        cmp("drain_empty", int'(a_empty), 1);

        // Rollback with wr_en in the error cycle (DEPTH=12).
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        settle();
        cmp("rollback_wr_addr", int'(b_wa), 3);
        cmp("rollback_pending", int'(b_pend), 0);
        cmp("rollback_count", int'(b_cnt), 3);

        // Non-power-of-two wrap (DEPTH=12).
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        settle();
        cmp("wrap_start_addr", int'(b_wa), 10);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("wrap_addr_11", int'(b_wa), 11);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("wrap_addr_0", int'(b_wa), 0);
        cmp("wrap_pulse", int'(b_wrap), 1);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("wrap_addr_1", int'(b_wa), 1);
        cmp("wrap_pulse_once", int'(b_wrap), 0);
        step(0, 0, 0, 0, 0, 1, 0);
        settle();
        cmp("wrap_rollback_addr", int'(b_wa), 10);
        cmp("wrap_rollback_nopulse", int'(b_wrap), 0);

        // Full and overflow (DEPTH=16).
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("full_flag", int'(a_full), 1);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("full_overflow", int'(a_ovf), 1);
        cmp("full_wr_addr", int'(a_wa), 0);
        step(0, 0, 0, 0, 1, 0, 0);
        settle();
        cmp("full_count", int'(a_cnt), 16);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        settle();
        cmp("underflow_pulse", int'(a_udf), 1);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        cmp("idle_overflow", int'(a_ovf), 1);

        // Clear mid-packet beats a same-cycle commit.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        settle();
        cmp("clear_count", int'(a_cnt), 0);
        cmp("clear_pending", int'(a_pend), 0);
        cmp("clear_in_pkt", int'(a_inpkt), 0);
        cmp("clear_wr_addr", int'(a_wa), 0);

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge tb_clk);
        #3;
        cmp("scoreboard_drained", q16.size() + q12.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_addr_counter.md
Name: pkt_addr_counter

Overview:
- Parametrised successor to the single-packet address counter.
- Generates write and read addresses for a circular packet buffer between the USB receive path and the Ethernet transmit path.
- Write side marks a packet start, advances per byte, then commits or rolls back to the marked address on error.
- Read side consumes committed data only; the block tracks committed and pending occupancy and flags full, empty, wrap and over/underflow.

Parameters:
ADDR_W, 4, width of wr_addr/rd_addr
DEPTH, 16, number of buffer entries; 2 <= DEPTH <= 2**ADDR_W; need not be a power of two

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock (clk), reset is synchronous and active-high
clear  in  1  synchronous soft clear; same effect as rst, lower priority
wr_start  in  1  begin packet: mark <= current wr_addr
wr_en  in  1  write one entry at wr_addr, advance wr_addr
wr_commit  in  1  end packet; pending entries become readable
wr_error  in  1  abort packet; wr_addr <= mark, pending discarded
rd_en  in  1  consume one committed entry at rd_addr, advance rd_addr
wr_addr  out  ADDR_W  current write address
rd_addr  out  ADDR_W  current read address
count  out  ADDR_W+1  committed occupancy
pending  out  ADDR_W+1  uncommitted entries of the open packet
full  out  1  count + pending == DEPTH
empty  out  1  count == 0
in_pkt  out  1  packet open (FSM in PKT)
wrap_flag  out  1  one-cycle pulse, cycle after wr_addr wraps DEPTH-1 -> 0
overflow  out  1  one-cycle pulse: wr_en ignored because full or not in packet
underflow  out  1  one-cycle pulse: rd_en ignored because empty

Behaviour:
- All outputs registered; full/empty may be decoded from registered count/pending.
- On rst or clear, at the next clk edge: wr_addr=0, rd_addr=0, mark=0, count=0, pending=0, in_pkt=0, full=0, empty=1, all pulses 0. rst mid-packet discards everything.
- Address increment: addr==DEPTH-1 -> 0, else addr+1. No arithmetic wraps at 2**ADDR_W unless DEPTH equals 2**ADDR_W.
- FSM IDLE:
  - wr_start -> PKT; mark<=wr_addr; pending<=0.
  - wr_en in IDLE without wr_start -> ignored, overflow pulse.
- FSM PKT:
  - wr_en and not full: wr_addr advances, pending+1.
  - wr_commit: count += pending (including the same-cycle write); pending<=0; -> IDLE.
  - wr_error: wr_addr<=mark; pending<=0; -> IDLE. Overrides wr_en and wr_commit in the same cycle.
  - wr_start while in PKT: implicit abort then restart; wr_addr<=mark, pending<=0, stay PKT.
- Same-cycle priority: rst > clear > wr_error > wr_start > wr_en/wr_commit.
  - wr_start with wr_en in the same cycle: mark = pre-write wr_addr and the write is counted in the new packet.
- Full: wr_en when count+pending==DEPTH -> no advance, overflow pulse. A same-cycle rd_en frees space only from the next cycle.
- Read: rd_en with count>0 -> rd_addr advances, count-1. With count==0 -> ignored, underflow pulse.
- Commit and read in the same cycle: count_next = count + pending_next - rd.
- wrap_flag: asserts the cycle after a wr_addr transition DEPTH-1 -> 0 caused by wr_en. Rollback across the wrap does not pulse.
- Latency: all effects visible one clk after the sampled inputs.

Test Plan:
- Reset (DEPTH=16): hold rst 2 cycles with wr_en=1, rd_en=1 -> wr_addr=0, rd_addr=0, count=0, empty=1, no pulses.
- Commit: wr_start+wr_en, then 3 wr_en, then wr_commit -> wr_addr=4, count=4, pending=0, in_pkt=0; 4 rd_en -> rd_addr=4, empty=1.
- Rollback (DEPTH=12): commit 3 entries, wr_start, 5 wr_en, wr_error with wr_en=1 -> wr_addr=3, pending=0, count=3.
- Non-power-of-two wrap (DEPTH=12):
  - Commit 10 entries and read 10.
  - Open a packet and write 3 -> wr_addr sequence 10, 11, 0, 1; wrap_flag pulses once.
  - Error -> wr_addr=10, no extra pulse.
- Full/overflow (DEPTH=16): write 16 in one packet -> full=1; 17th wr_en -> overflow pulse, wr_addr unchanged.
- Full/overflow, continued: commit -> count=16; rd_en on empty after draining -> underflow pulse; wr_en in IDLE -> overflow pulse.
- Clear mid-packet: 6 pending with clear=1 and wr_commit=1 -> count=0, pending=0, in_pkt=0, wr_addr=0.
